seq_1011_frame_tx: RTL
======================

// Module: seq_1011_frame_tx
// PURPOSE
//  Serial frame transmitter; the sending end of the team's 1011 serial link.
//  - Accepts a parallel word over a VALID/READY handshake.
//  - Emits preamble 1011, then the word MSB-first, then GAP idle zeros, one bit per CLK.
//  - Drives the serial input of the 1011 non-overlapping Moore detector and the
//    downstream deserializer.
// PARAMETERS
//  DATA_W  8  payload width in bits, >=1
//  GAP     2  idle zero bits forced after each payload, >=0
//  CNT_W   8  width of the completed-frame counter
// PORTS
//  CLK      in   1        clock, all logic on rising edge
//  RST      in   1        synchronous, active-high reset
//  VALID    in   1        DATA holds a word to send
//  DATA     in   DATA_W   payload word, sampled only on handshake edge
//  READY    out  1        block can accept a word (high only in IDLE)
//  ABORT    in   1        synchronous frame kill
//  OUT      out  1        serial bit stream, registered
//  BUSY     out  1        frame in progress (= !READY)
//  DONE     out  1        one-cycle pulse: frame completed normally
//  FRM_CNT  out  CNT_W    count of completed frames, wraps modulo 2**CNT_W
// BEHAVIOUR
//  - Reset (RST=1 at edge): next cycle state=IDLE, OUT=0, READY=1, BUSY=0,
//    DONE=0, FRM_CNT=0, shift register cleared. RST overrides every other input.
//  - States: IDLE -> PRE (4 bits) -> DAT (DATA_W bits) -> GAP (GAP bits) -> IDLE.
//    GAP=0 goes DAT -> IDLE directly.
//  - Handshake: transfer occurs at edge E0 where VALID&&READY. DATA is latched at E0.
//    VALID while BUSY is ignored; changes to DATA after E0 have no effect.
//    READY is decoded from registered state only (no combinational path from VALID/ABORT).
//  - OUT timing after E0: cycles 1..4 = 1,0,1,1; cycles 5..4+DATA_W = DATA[DATA_W-1]..DATA[0];
//    next GAP cycles = 0. IDLE always drives OUT=0.
//  - READY falls in cycle 1 and returns in cycle 5+DATA_W+GAP.
//  - Minimum frame spacing is 5+DATA_W+GAP cycles (READY must be seen high for 1 cycle).
//    This guarantees at least 1+GAP zeros between frames.
//  - DONE=1 only in the first IDLE cycle following a normally completed frame.
//    FRM_CNT increments in that same cycle, so FRM_CNT and DONE update together.
//    At 2**CNT_W-1, FRM_CNT wraps to 0.
//  - ABORT=1 at an edge while BUSY: next cycle IDLE, OUT=0, READY=1.
//    No DONE, FRM_CNT unchanged, remaining bits dropped.
//  - ABORT in IDLE has no effect; a simultaneous VALID handshake is accepted normally.
//  - ABORT and RST together: RST behaviour.
//  - Back-to-back: with VALID held high, a new word is accepted at the end of the one-cycle
//    IDLE, in the same edge DONE is high.
// TESTING
//  1. RST, DATA_W=8, GAP=2, DATA=8'hA5 handshake at E0
//     -> OUT = 1011_10100101_00, READY high in cycle 15, DONE pulse in cycle 15,
//        FRM_CNT=1.
//  2. Loop OUT into the 1011 Moore detector, send 8'h00 x4
//     -> exactly 4 detector pulses, each at preamble end, none in payload or gap.
//  3. VALID held high, words 8'hFF,8'h12,8'h80 -> three frames, 1+GAP zeros between each,
//     FRM_CNT=3, READY high exactly 1 cycle between frames.
//  4. VALID pulsed with DATA=8'h3C during cycles 3..10 of a busy frame
//     -> ignored, only original frame sent, FRM_CNT +1.
//  5. ABORT in cycle 7 (third data bit) -> OUT=0 and READY=1 next cycle, no DONE,
//     FRM_CNT unchanged. The next handshake sends a full, correct frame.
//  6. RST mid-preamble, and with CNT_W=2 send 5 frames
//     -> RST gives all reset values next cycle; FRM_CNT sequence 1,2,3,0,1.

Source files
------------

// File: rtl/seq_1011_frame_tx.sv
// Serial frame transmitter for the 1011 link: sends the preamble, then the
// payload MSB-first, then idle gap zeros. Words arrive over VALID/READY.
module seq_1011_frame_tx #(
  parameter int DATA_W = 8,
  parameter int GAP    = 2,
  parameter int CNT_W  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              VALID,
  input  logic [DATA_W-1:0] DATA,
  output logic              READY,
  input  logic              ABORT,
  output logic              OUT,
  output logic              BUSY,
  output logic              DONE,
  output logic [CNT_W-1:0]  FRM_CNT
);

  localparam int LEN    = (DATA_W > GAP) ? DATA_W : GAP;
  localparam int CW     = $clog2(LEN + 4) + 1;
  localparam int GAP_M1 = (GAP > 0) ? GAP - 1 : 0;
  localparam logic [3:0] PRE = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_DAT,
    S_GAP
  } state_t;

  state_t state, state_n;

  logic [CW-1:0]     bit_q, bit_n;
  logic [DATA_W-1:0] sr_q, sr_n;
  logic              out_q, out_n;
  logic              done_q, done_n;
  logic [CNT_W-1:0]  frm_q, frm_n;
  logic [1:0]        pre_idx;
  logic              last;

  // bit_q holds the index of the bit on OUT this cycle within its field
  assign last    = (bit_q == '0);
  assign pre_idx = bit_q[1:0] - 2'd1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= S_IDLE;
      bit_q  <= '0;
      sr_q   <= '0;
      out_q  <= 1'b0;
      done_q <= 1'b0;
      frm_q  <= '0;
    end else begin
      state  <= state_n;
      bit_q  <= bit_n;
      sr_q   <= sr_n;
      out_q  <= out_n;
      done_q <= done_n;
      frm_q  <= frm_n;
    end
  end

  always_comb begin
    state_n = state;
    bit_n   = bit_q;
    sr_n    = sr_q;
    out_n   = 1'b0;
    done_n  = 1'b0;
    frm_n   = frm_q;
    unique case (state)
      S_IDLE: begin
        if (VALID) begin
          state_n = S_PRE;
          bit_n   = CW'(3);
          sr_n    = DATA;
          out_n   = PRE[3];
        end
      end
      S_PRE: begin
        if (!last) begin
          bit_n = bit_q - CW'(1);
          out_n = PRE[pre_idx];
        end else begin
          state_n = S_DAT;
          bit_n   = CW'(DATA_W - 1);
          out_n   = sr_q[DATA_W-1];
          sr_n    = sr_q << 1;
        end
      end
      S_DAT: begin
        if (!last) begin
          bit_n = bit_q - CW'(1);
          out_n = sr_q[DATA_W-1];
          sr_n  = sr_q << 1;
        end else if (GAP > 0) begin
          state_n = S_GAP;
          bit_n   = CW'(GAP_M1);
        end else begin
          state_n = S_IDLE;
          done_n  = 1'b1;
          frm_n   = frm_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (!last) begin
          bit_n = bit_q - CW'(1);
        end else begin
          state_n = S_IDLE;
          done_n  = 1'b1;
          frm_n   = frm_q + CNT_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
    // a kill drops the rest of the frame without counting it
    if (ABORT && state != S_IDLE) begin
      state_n = S_IDLE;
      bit_n   = '0;
      out_n   = 1'b0;
      done_n  = 1'b0;
      frm_n   = frm_q;
    end
  end

  assign READY   = (state == S_IDLE);
  assign BUSY    = ~READY;
  assign OUT     = out_q;
  assign DONE    = done_q;
  assign FRM_CNT = frm_q;

endmodule
